// File: rtl/pc_ras_if.sv
// pc_ras_if: fetch-control request/status bundle between sequencer (master) and PC unit (slave)
interface pc_ras_if #(
    parameter int AW    = 6,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);
    logic          stall;
    logic          jmp_en;
    logic [AW-1:0] jmp_addr;
    logic          br_en;
    logic [AW-1:0] br_off;
    logic          call_en;
    logic [AW-1:0] call_addr;
    logic          ret_en;
    logic          err_clr;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] ras_depth;
    logic          ras_empty;
    logic          ras_full;
    logic          err_ovf;
    logic          err_unf;
    modport master (
        output stall, jmp_en, jmp_addr, br_en, br_off, call_en, call_addr, ret_en, err_clr,
        input  pc_out, ras_depth, ras_empty, ras_full, err_ovf, err_unf
    );
    modport slave (
        input  stall, jmp_en, jmp_addr, br_en, br_off, call_en, call_addr, ret_en, err_clr,
        output pc_out, ras_depth, ras_empty, ras_full, err_ovf, err_unf
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: fetch PC with stall/branch/jump/call/return and return-address stack; PC_RAS_WRAP_EN makes the RAS circular
module pc_ras #(
    parameter int            AW        = 6,
    parameter int            DEPTH     = 4,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic clk,
    input  logic rst_n,
    pc_ras_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] pc, pc_inc, pc_nxt;
    logic [AW-1:0] stack [DEPTH];
    logic [DW-1:0] depth, depth_nxt;
    logic [PW-1:0] top, wr_idx;
    logic          ovf, unf, empty, full;
    logic          do_ret, do_call, pop, push, ovf_set, unf_set;
    assign empty   = depth == '0;
    assign full    = depth == DW'(DEPTH);
    assign pc_inc  = pc + AW'(1);
    assign do_ret  = !bus.stall && bus.ret_en;
    assign do_call = !bus.stall && !bus.ret_en && bus.call_en;
    assign pop     = do_ret && !empty;
    assign unf_set = do_ret && empty;
`ifdef PC_RAS_WRAP_EN
    // Write pointer runs independently of depth so a full push can overwrite the oldest slot.
    logic [PW-1:0] wp;
    assign wr_idx  = wp;
    assign top     = (wp == '0) ? PW'(DEPTH - 1) : wp - PW'(1);
    assign push    = do_call;
    assign ovf_set = 1'b0;
    always_ff @(posedge clk) begin
        if (!rst_n)
            wp <= '0;
        else if (pop)
            wp <= top;
        else if (push)
            wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
    end
`else
    assign wr_idx  = depth[PW-1:0];
    assign top     = depth[PW-1:0] - PW'(1);
    assign push    = do_call && !full;
    assign ovf_set = do_call && full;
`endif
    always_comb begin
        pc_nxt = bus.stall   ? pc :
                 bus.ret_en  ? (empty ? pc_inc : stack[top]) :
                 bus.call_en ? bus.call_addr :
                 bus.jmp_en  ? bus.jmp_addr :
                 bus.br_en   ? pc + bus.br_off :
                               pc_inc;
        depth_nxt = pop             ? depth - DW'(1) :
                    (push && !full) ? depth + DW'(1) :
                                      depth;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= RESET_VEC;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            depth <= depth_nxt;
            ovf   <= ovf_set | (ovf & ~bus.err_clr);
            unf   <= unf_set | (unf & ~bus.err_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && push)
            stack[wr_idx] <= pc_inc;
    end
    assign bus.pc_out    = pc;
    assign bus.ras_depth = depth;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.err_ovf   = ovf;
    assign bus.err_unf   = unf;
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: random and directed stimulus against a queue-based reference model of pc_ras
module tb_pc_ras;
    localparam int AW = 6;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_q [$];
    logic m_ovf, m_unf;
    pc_ras_if #(.AW(AW), .DEPTH(DEPTH)) b ();
    pc_ras #(.AW(AW), .DEPTH(DEPTH), .RESET_VEC('0)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic clr();
        b.stall = 0; b.jmp_en = 0; b.jmp_addr = '0; b.br_en = 0; b.br_off = '0;
        b.call_en = 0; b.call_addr = '0; b.ret_en = 0; b.err_clr = 0;
    endtask
    // Reference: queue back is the stack top; front is the oldest entry.
    task automatic model_step();
        logic so, su;
        so = 0; su = 0;
        if (!rst_n) begin
            m_pc = '0; m_q.delete(); m_ovf = 0; m_unf = 0;
            return;
        end
        if (b.stall) begin
        end else if (b.ret_en) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin m_pc = m_pc + 1; su = 1; end
        end else if (b.call_en) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pc + 1);
            else begin
`ifdef PC_RAS_WRAP_EN
                void'(m_q.pop_front());
                m_q.push_back(m_pc + 1);
`else
                so = 1;
`endif
            end
            m_pc = b.call_addr;
        end else if (b.jmp_en) m_pc = b.jmp_addr;
        else if (b.br_en) m_pc = m_pc + b.br_off;
        else m_pc = m_pc + 1;
        m_ovf = so | (m_ovf & ~b.err_clr);
        m_unf = su | (m_unf & ~b.err_clr);
    endtask
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("pc", int'(b.pc_out), int'(m_pc));
        check("depth", int'(b.ras_depth), m_q.size());
        check("empty", int'(b.ras_empty), int'(m_q.size() == 0));
        check("full", int'(b.ras_full), int'(m_q.size() == DEPTH));
        check("ovf", int'(b.err_ovf), int'(m_ovf));
        check("unf", int'(b.err_unf), int'(m_unf));
    endtask
    task automatic jump(input logic [AW-1:0] a);
        clr(); b.jmp_en = 1; b.jmp_addr = a; cyc(); clr();
    endtask
    task automatic call(input logic [AW-1:0] a);
        clr(); b.call_en = 1; b.call_addr = a; cyc(); clr();
    endtask
    task automatic ret();
        clr(); b.ret_en = 1; cyc(); clr();
    endtask
    initial begin
        clr();
        m_pc = '0; m_ovf = 0; m_unf = 0;
        cyc();
        check("rst_pc", int'(b.pc_out), 0);
        rst_n = 1;
        for (int i = 1; i <= 70; i++) begin
            cyc();
            check("idle_pc", int'(b.pc_out), i % 64);
        end
        jump(10);
        b.stall = 1;
        repeat (3) begin cyc(); check("stall_hold", int'(b.pc_out), 10); end
        clr(); cyc();
        check("stall_rel", int'(b.pc_out), 11);
        jump(5);
        b.br_en = 1; b.br_off = 6'h3E; cyc(); clr();
        check("br_back", int'(b.pc_out), 3);
        jump(62);
        b.br_en = 1; b.br_off = 6'd5; cyc(); clr();
        check("br_wrap", int'(b.pc_out), 3);
        b.jmp_en = 1; b.jmp_addr = 40; b.br_en = 1; b.br_off = 6'd1; cyc(); clr();
        check("jmp_over_br", int'(b.pc_out), 40);
        jump(2);
        call(20); check("call1_pc", int'(b.pc_out), 20); check("call1_d", int'(b.ras_depth), 1);
        call(30); check("call2_pc", int'(b.pc_out), 30); check("call2_d", int'(b.ras_depth), 2);
        ret();    check("ret1_pc", int'(b.pc_out), 21);  check("ret1_d", int'(b.ras_depth), 1);
        ret();    check("ret2_pc", int'(b.pc_out), 3);   check("ret2_d", int'(b.ras_depth), 0);
        call(50);
        b.call_en = 1; b.call_addr = 12; b.ret_en = 1; cyc(); clr();
        check("callret_pc", int'(b.pc_out), 4);
        check("callret_d", int'(b.ras_depth), 0);
        jump(8);
        for (int i = 0; i < 5; i++) call(AW'(16 + 8 * i));
        check("nest_pc", int'(b.pc_out), 48);
        check("nest_d", int'(b.ras_depth), DEPTH);
`ifdef PC_RAS_WRAP_EN
        check("nest_ovf", int'(b.err_ovf), 0);
        ret(); check("wret_newest", int'(b.pc_out), 41);
`else
        check("nest_ovf", int'(b.err_ovf), 1);
        ret(); check("ret_drop", int'(b.pc_out), 33);
`endif
        repeat (3) ret();
        ret();
        check("unf_pc_d", int'(b.ras_depth), 0);
        check("unf_flag", int'(b.err_unf), 1);
        b.err_clr = 1; cyc(); clr();
        check("clr_ovf", int'(b.err_ovf), 0);
        check("clr_unf", int'(b.err_unf), 0);
        b.err_clr = 1; b.ret_en = 1; cyc(); clr();
        check("set_wins", int'(b.err_unf), 1);
        call(10); call(20); call(45);
        check("mid_pc", int'(b.pc_out), 45);
        rst_n = 0; b.call_en = 1; b.call_addr = 7; cyc(); rst_n = 1; clr();
        check("mid_rst_pc", int'(b.pc_out), 0);
        check("mid_rst_d", int'(b.ras_depth), 0);
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            b.stall = ($urandom_range(0, 7) == 0);
            b.ret_en = ($urandom_range(0, 3) == 0);
            b.call_en = ($urandom_range(0, 3) == 0);
            b.jmp_en = ($urandom_range(0, 5) == 0);
            b.br_en = ($urandom_range(0, 4) == 0);
            b.err_clr = ($urandom_range(0, 9) == 0);
            b.jmp_addr = AW'($urandom);
            b.br_off = AW'($urandom);
            b.call_addr = AW'($urandom);
            cyc();
        end
        rst_n = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised program counter for the instruction-fetch stage. Output drives the IMEM address.
- Adds to the basic increment/load PC: stall, PC-relative branch, absolute jump, and call/return with a hardware return-address stack (RAS).
- Provides sticky RAS overflow/underflow error flags for the debug/status logic.

Parameters:
AW, 6, PC/address width in bits (IMEM depth 2^AW)
DEPTH, 4, RAS entries (>=2)
RESET_VEC, 0, PC value loaded at reset (AW bits)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
stall  in  1  hold PC and RAS this cycle
jmp_en  in  1  absolute jump request
jmp_addr  in  AW  jump target
br_en  in  1  relative branch request
br_off  in  AW  signed two's-complement branch offset
call_en  in  1  call request: push return address, jump to call_addr
call_addr  in  AW  call target
ret_en  in  1  return request: pop RAS into PC
err_clr  in  1  clear sticky error flags
pc_out  out  AW  current PC (registered)
ras_depth  out  $clog2(DEPTH+1)  number of valid RAS entries
ras_empty  out  1  ras_depth==0 (combinational from state)
ras_full  out  1  ras_depth==DEPTH (combinational from state)
err_ovf  out  1  sticky: call attempted with RAS full
err_unf  out  1  sticky: return attempted with RAS empty

Behaviour:
- Reset (rst_n=0 at posedge): pc_out<=RESET_VEC, ras_depth<=0, err_ovf<=0, err_unf<=0. RAS contents are don't-care. Reset overrides all other inputs, including in mid-sequence.
- Per-cycle priority, one action only: rst > stall > ret_en > call_en > jmp_en > br_en > increment. Lower-priority requests in the same cycle are ignored, not queued.
- stall: pc_out, RAS and ras_depth hold. err_clr is still honoured under stall.
- Increment: pc_out<=pc_out+1, modulo 2^AW (2^AW-1 wraps to 0).
- jmp: pc_out<=jmp_addr.
- br: pc_out<=pc_out+br_off, AW-bit add with carry discarded (wraps both directions).
- call, RAS not full: push (pc_out+1 mod 2^AW), ras_depth+1, pc_out<=call_addr.
- call, RAS full: pc_out<=call_addr, push dropped, ras_depth stays DEPTH, err_ovf<=1 (see optional feature).
- ret, RAS not empty: pc_out<=top entry, ras_depth-1.
- ret, RAS empty: pc_out<=pc_out+1, err_unf<=1.
- ret and call in the same cycle: ret wins, call is ignored.
- Error flags: set on the cycle of the error event and remain 1 until err_clr. If err_clr and a new error event occur in the same cycle, set wins.
- Latency: every request takes effect on pc_out at the next rising edge. No combinational path from any input to pc_out.
- RAS storage is a register array with a top pointer derived from ras_depth. LIFO order is required.

Optional Feature:
- Macro: PC_RAS_WRAP_EN.
- Defined: the RAS is circular. A call when full overwrites the oldest entry, ras_depth stays DEPTH, and err_ovf is not set. The subsequent DEPTH returns yield the newest DEPTH return addresses in LIFO order; the next return then sees the stack as empty (underflow rule).
- Undefined: overflow behaviour as stated in Behaviour (push dropped, err_ovf set).

Test Plan (AW=6, DEPTH=4, RESET_VEC=0):
- Reset, then 70 idle cycles -> pc_out 0,1,...,63,0,1,...; ras_depth=0, errors 0.
- At pc=10, stall=1 for 3 cycles, then release -> pc_out holds 10 for 3 cycles, then 11.
- At pc=5, br_en=1, br_off=6'h3E (-2) -> pc=3. At pc=62, br_off=5 -> pc=3 (wrap). At pc=3, jmp_en+br_en with jmp_addr=40 -> pc=40.
- Calls at pc=2 (to 20), pc=20 (to 30), then ret, then ret -> pc 20, 30, 21, 3. ras_depth goes 1, 2, 1, 0. Same-cycle call_en+ret_en at depth 1 -> pops only.
- 5 nested calls from depth 0 (no macro) -> 5th still jumps, ras_depth=4, err_ovf=1. 5 rets -> 4 pops, 5th gives pc+1 and err_unf=1. err_clr -> both flags 0. With PC_RAS_WRAP_EN, err_ovf stays 0 and the 4 rets return the newest 4 addresses.
- rst_n=0 asserted at depth 3 with pc=45 mid-sequence -> next edge pc=0, ras_depth=0, flags 0.
